counter_sched: RTL

COUNTER_SCHED -- requirements
Module: counter_sched

---
 rtl/counter_sched.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/counter_sched.sv
// counter_sched: two-requester round-robin command scheduler driving an
// external 8-bit counter (CLEAR / LOAD / UP n / DOWN n).
// Optional build macro CNT_SCHED_SAT_EN: UP/DOWN stop at 8'hFF / 8'h00 and
// pulse sat with done; without it counting wraps and sat is tied low.
module counter_sched (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [1:0] cmd0,
    input  logic [1:0] cmd1,
    input  logic [7:0] arg0,
    input  logic [7:0] arg1,
    output logic [1:0] gnt,
    output logic [1:0] done,
    output logic       busy,
    output logic       sat,
    output logic       cnt_rst,
    output logic       cnt_load,
    output logic       cnt_up,
    output logic [7:0] cnt_loadin,
    input  logic [7:0] cnt_y
);

    localparam int unsigned W = 8;

    localparam logic [1:0] CMD_CLEAR = 2'b00;
    localparam logic [1:0] CMD_LOAD  = 2'b01;
    localparam logic [1:0] CMD_UP    = 2'b10;
    localparam logic [1:0] CMD_DOWN  = 2'b11;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_EXEC = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

    logic [1:0]   state_q, state_d;
    logic         idx_q, idx_d;
    logic         last_q, last_d;
    logic [1:0]   cmd_q, cmd_d;
    logic [W-1:0] arg_q, arg_d;
    logic [W-1:0] step_q, step_d;

    logic         win;
    logic [1:0]   win_cmd;
    logic [W-1:0] win_arg;
    logic         sat_hit;

    // Round-robin pick: on contention the requester not granted last wins
    always_comb begin
        win = req[1];
        if (req == 2'b11) begin
            win = ~last_q;
        end
        win_cmd = win ? cmd1 : cmd0;
        win_arg = win ? arg1 : arg0;
    end

`ifdef CNT_SCHED_SAT_EN
    logic sat_q, sat_d;

    assign sat_hit = (state_q == S_EXEC) &&
                     (((cmd_q == CMD_UP)   && (cnt_y == '1)) ||
                      ((cmd_q == CMD_DOWN) && (cnt_y == '0)));

    // Saturation flag: set by the EXEC cycle that hits a limit, shown in DONE
    always_comb begin
        sat_d = !rst && sat_hit;
    end

    // Saturation flag register
    always_ff @(posedge clk) begin
        sat_q <= sat_d;
    end

    assign sat = !rst && (state_q == S_DONE) && sat_q;
`else
    assign sat_hit = 1'b0;
    assign sat     = 1'b0;
`endif

    // Next-state and counter-drive decode; counter is held unless EXEC steps it
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        last_d     = last_q;
        cmd_d      = cmd_q;
        arg_d      = arg_q;
        step_d     = step_q;
        gnt        = 2'b00;
        done       = 2'b00;
        busy       = 1'b0;
        cnt_rst    = 1'b0;
        cnt_load   = 1'b1;
        cnt_up     = 1'b0;
        cnt_loadin = cnt_y;

        if (rst) begin
            state_d    = S_IDLE;
            idx_d      = 1'b0;
            last_d     = 1'b1;
            cmd_d      = CMD_CLEAR;
            arg_d      = '0;
            step_d     = '0;
            cnt_rst    = 1'b1;
            cnt_load   = 1'b0;
            cnt_loadin = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req != 2'b00) begin
                        gnt[win] = 1'b1;
                        idx_d    = win;
                        last_d   = win;
                        cmd_d    = win_cmd;
                        arg_d    = win_arg;
                        step_d   = win_arg;
                        // A zero-step count has nothing to execute
                        if (win_cmd[1] && (win_arg == '0)) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    busy = 1'b1;
                    case (cmd_q)
                        CMD_CLEAR: begin
                            cnt_rst  = 1'b1;
                            cnt_load = 1'b0;
                            state_d  = S_DONE;
                        end
                        CMD_LOAD: begin
                            cnt_loadin = arg_q;
                            state_d    = S_DONE;
                        end
                        default: begin
                            if (sat_hit) begin
                                state_d = S_DONE;
                            end else begin
                                cnt_load = 1'b0;
                                cnt_up   = (cmd_q == CMD_UP);
                                if (step_q == W'(1)) begin
                                    state_d = S_DONE;
                                end else begin
                                    step_d = step_q - W'(1);
                                end
                            end
                        end
                    endcase
                end
                S_DONE: begin
                    busy        = 1'b1;
                    done[idx_q] = 1'b1;
                    state_d     = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and captured-command registers (reset folded into the _d logic)
    always_ff @(posedge clk) begin
        state_q <= state_d;
        idx_q   <= idx_d;
        last_q  <= last_d;
        cmd_q   <= cmd_d;
        arg_q   <= arg_d;
        step_q  <= step_d;
    end

endmodule
